// File: rtl/gty_rx_pkg.sv
// Shared definitions for the GTY RX 64b/66b block-sync path.
//   - sync_state_e : block-lock FSM states
//   - SYNC_DATA / SYNC_CTRL : the two legal 66b sync header values
//   - SCR_TAP_A / SCR_TAP_B : descrambler taps (x^58 + x^39 + 1)
//   - DEF_* : default lock / window / unlock / slip-wait settings
package gty_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } sync_state_e;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int SCR_TAP_A = 38;
  localparam int SCR_TAP_B = 57;

  localparam int DEF_LOCK_COUNT  = 64;
  localparam int DEF_WINDOW_SIZE = 1024;
  localparam int DEF_UNLOCK_BAD  = 16;
  localparam int DEF_SLIP_WAIT   = 32;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/gty_rx_block_sync_descrambler.sv
// Self-synchronising 64-bit descrambler, polynomial x^58 + x^39 + 1.
// Ports:
//   clk_i    : clock
//   srst_i   : synchronous active-high reset, clears the 58-bit history
//   en_i     : advance the history with data_i (one block present)
//   bypass_i : output data_i unchanged (history still advances)
//   data_i   : scrambled payload, bit 0 received first
//   data_o   : descrambled payload (combinational from data_i and history)
module gty_rx_descrambler64
  import gty_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        en_i,
  input  logic        bypass_i,
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);

  // state_q[0] is the most recently received scrambled bit.
  logic [57:0]  state_q;
  logic [57:0]  state_d;
  // Flat history in arrival order: hist[0] is the oldest stored bit,
  // hist[58+i] is data_i[i]. Bit i then sees s[k] at hist[57+i-k].
  logic [121:0] hist;

  assign hist[121:58] = data_i;

  for (genvar gi = 0; gi < 58; gi++) begin : g_hist
    assign hist[gi] = state_q[57-gi];
  end

  for (genvar gi = 0; gi < 64; gi++) begin : g_out
    assign data_o[gi] = bypass_i ? data_i[gi]
                      : data_i[gi] ^ hist[gi+57-SCR_TAP_A] ^ hist[gi+57-SCR_TAP_B];
  end

  // After a full block the newest 58 input bits form the history.
  for (genvar gi = 0; gi < 58; gi++) begin : g_next
    assign state_d[gi] = data_i[63-gi];
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= '0;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/gty_rx_block_sync.sv
// GTY RX 64b/66b block lock, descrambling and one-deep output buffer.
// Ports:
//   aclk, areset         : clock and synchronous active-high reset
//   gty_rx_data/_datavalid/_header/_headervalid : gearbox user interface
//   gty_rx_gearboxslip   : one-cycle slip request while hunting
//   out_data/_valid/_header/_header_valid, out_ready : downstream stream
//   block_lock           : lock status
//   drop_cnt, slip_cnt   : saturating drop / slip counters
module gty_rx_block_sync
  import gty_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
  parameter int UNLOCK_BAD  = DEF_UNLOCK_BAD,
  parameter int SLIP_WAIT   = DEF_SLIP_WAIT,
  parameter int DESCRAMBLE  = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] gty_rx_data,
  input  logic                  gty_rx_datavalid,
  input  logic [1:0]            gty_rx_header,
  input  logic                  gty_rx_headervalid,
  output logic                  gty_rx_gearboxslip,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [1:0]            out_header,
  output logic                  out_header_valid,
  input  logic                  out_ready,
  output logic                  block_lock,
  output logic [15:0]           drop_cnt,
  output logic [15:0]           slip_cnt
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
  localparam int HDR_W  = $clog2(WINDOW_SIZE + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [GOOD_W-1:0] LOCK_LAST   = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  UNLOCK_LAST = BAD_W'(UNLOCK_BAD - 1);
  localparam logic [HDR_W-1:0]  WIN_LAST    = HDR_W'(WINDOW_SIZE - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(SLIP_WAIT - 1);

  sync_state_e       state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic [HDR_W-1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       slip_cnt_q, slip_cnt_d;

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_header_q, out_header_d;
  logic                  out_valid_q, out_valid_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  blk_present;
  logic                  hdr_ok;
  logic [DATA_WIDTH-1:0] descr_data;

  assign blk_present = gty_rx_datavalid & gty_rx_headervalid;
  assign hdr_ok      = hdr_is_valid(gty_rx_header);

  // Runs in every FSM state so the history has converged before lock.
  gty_rx_descrambler64 u_descr (
    .clk_i    (aclk),
    .srst_i   (areset),
    .en_i     (blk_present),
    .bypass_i (DESCRAMBLE == 0),
    .data_i   (gty_rx_data),
    .data_o   (descr_data)
  );

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_HUNT;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      hdr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    slip_cnt_d = slip_cnt_q;
    case (state_q)
      ST_HUNT: begin
        if (blk_present) begin
          if (!hdr_ok) begin
            good_cnt_d = '0;
            state_d    = ST_SLIP;
          end else if (good_cnt_q == LOCK_LAST) begin
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            hdr_cnt_d  = '0;
            state_d    = ST_LOCKED;
          end else begin
            good_cnt_d = good_cnt_q + GOOD_W'(1);
          end
        end
      end
      ST_SLIP: begin
        if (slip_cnt_q != 16'hFFFF) begin
          slip_cnt_d = slip_cnt_q + 16'd1;
        end
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // Cycles, not blocks, are counted: the gearbox needs settling time.
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          good_cnt_d = '0;
          state_d    = ST_HUNT;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (blk_present) begin
          // Unlock is tested first so it wins over a coincident window end.
          if (!hdr_ok && (bad_cnt_q == UNLOCK_LAST)) begin
            bad_cnt_d = '0;
            hdr_cnt_d = '0;
            state_d   = ST_SLIP;
          end else if (hdr_cnt_q == WIN_LAST) begin
            bad_cnt_d = '0;
            hdr_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
            if (!hdr_ok) begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // FSM outputs
  always_comb begin
    block_lock         = (state_q == ST_LOCKED);
    gty_rx_gearboxslip = (state_q == ST_SLIP);
  end

  // One-deep output buffer: a locked block loads when the slot is free or
  // being emptied this cycle, otherwise it is dropped and counted.
  always_comb begin
    out_data_d   = out_data_q;
    out_header_d = out_header_q;
    out_valid_d  = out_valid_q;
    drop_cnt_d   = drop_cnt_q;
    if (blk_present && (state_q == ST_LOCKED)) begin
      if (!out_valid_q || out_ready) begin
        out_data_d   = descr_data;
        out_header_d = gty_rx_header;
        out_valid_d  = 1'b1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_data_q   <= '0;
      out_header_q <= '0;
      out_valid_q  <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_header_q <= out_header_d;
      out_valid_q  <= out_valid_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign out_data         = out_data_q;
  assign out_header       = out_header_q;
  assign out_valid        = out_valid_q;
  assign out_header_valid = out_valid_q;
  assign drop_cnt         = drop_cnt_q;
  assign slip_cnt         = slip_cnt_q;

endmodule

// File: tb/tb_gty_rx_block_sync.sv
module tb_gty_rx_block_sync;

  localparam int LOCK_COUNT  = 64;
  localparam int WINDOW_SIZE = 1024;
  localparam int UNLOCK_BAD  = 16;
  localparam int SLIP_WAIT   = 32;

  logic        aclk = 1'b0;
  logic        areset;
  logic [63:0] gty_rx_data;
  logic        gty_rx_datavalid;
  logic [1:0]  gty_rx_header;
  logic        gty_rx_headervalid;
  logic        gty_rx_gearboxslip;
  logic [63:0] out_data;
  logic        out_valid;
  logic [1:0]  out_header;
  logic        out_header_valid;
  logic        out_ready;
  logic        block_lock;
  logic [15:0] drop_cnt;
  logic [15:0] slip_cnt;

  always #5 aclk = ~aclk;

  gty_rx_block_sync dut (
    .aclk               (aclk),
    .areset             (areset),
    .gty_rx_data        (gty_rx_data),
    .gty_rx_datavalid   (gty_rx_datavalid),
    .gty_rx_header      (gty_rx_header),
    .gty_rx_headervalid (gty_rx_headervalid),
    .gty_rx_gearboxslip (gty_rx_gearboxslip),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_header         (out_header),
    .out_header_valid   (out_header_valid),
    .out_ready          (out_ready),
    .block_lock         (block_lock),
    .drop_cnt           (drop_cnt),
    .slip_cnt           (slip_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: lock flag, run/window tallies and an "ignore" countdown
  // covering the slip cycle plus the wait period.
  logic        m_lock;
  int          m_good, m_ign, m_wblk, m_wbad;
  logic [57:0] m_s;
  logic [15:0] m_slip_cnt, m_drop;
  logic        m_valid;
  logic [63:0] m_data;
  logic [1:0]  m_hdr;

  // Test-side scrambler state
  logic [57:0] sc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 1'b0; m_good = 0; m_ign = 0; m_wblk = 0; m_wbad = 0;
    m_s = '0; m_slip_cnt = '0; m_drop = '0;
    m_valid = 1'b0; m_data = '0; m_hdr = '0;
  endtask

  task automatic model_step();
    logic        present, ok;
    logic [63:0] d;
    logic [57:0] s;
    present = gty_rx_datavalid && gty_rx_headervalid;
    ok = (gty_rx_header == 2'b01) || (gty_rx_header == 2'b10);
    s = m_s;
    for (int i = 0; i < 64; i++) begin
      d[i] = gty_rx_data[i] ^ s[38] ^ s[57];
      s = {s[56:0], gty_rx_data[i]};
    end
    if (present && m_lock) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1; m_data = d; m_hdr = gty_rx_header;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (present) m_s = s;
    if (m_ign == SLIP_WAIT + 1 && m_slip_cnt != 16'hFFFF) m_slip_cnt = m_slip_cnt + 16'd1;
    if (m_ign > 0) begin
      m_ign--;
    end else if (present) begin
      if (!m_lock) begin
        if (ok) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin
            m_lock = 1'b1; m_good = 0; m_wblk = 0; m_wbad = 0;
          end
        end else begin
          m_good = 0; m_ign = SLIP_WAIT + 1;
        end
      end else begin
        m_wblk++;
        if (!ok) m_wbad++;
        if (m_wbad == UNLOCK_BAD) begin
          m_lock = 1'b0; m_ign = SLIP_WAIT + 1; m_wblk = 0; m_wbad = 0;
        end else if (m_wblk == WINDOW_SIZE) begin
          m_wblk = 0; m_wbad = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("block_lock", 64'(block_lock), 64'(m_lock));
    check("gearboxslip", 64'(gty_rx_gearboxslip), 64'(m_ign == SLIP_WAIT + 1));
    check("slip_cnt", 64'(slip_cnt), 64'(m_slip_cnt));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_header_valid", 64'(out_header_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_header", 64'(out_header), 64'(m_hdr));
    end
  endtask

  task automatic cycle(input logic dv, input logic hv, input logic [1:0] h,
                       input logic [63:0] d, input logic rdy);
    gty_rx_datavalid   = dv;
    gty_rx_headervalid = hv;
    gty_rx_header      = h;
    gty_rx_data        = d;
    out_ready          = rdy;
    @(posedge aclk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    gty_rx_datavalid = 1'b0; gty_rx_headervalid = 1'b0;
    gty_rx_header = 2'b00; gty_rx_data = '0; out_ready = 1'b0;
    @(posedge aclk);
    model_reset();
    #1;
    compare_all();
    check("rst_block_lock", 64'(block_lock), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_slip_cnt", 64'(slip_cnt), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    areset = 1'b0;
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble(input logic [63:0] p, output logic [63:0] c);
    for (int i = 0; i < 64; i++) begin
      c[i] = p[i] ^ sc[38] ^ sc[57];
      sc = {sc[56:0], c[i]};
    end
  endtask

  // One locked window of WINDOW_SIZE blocks with bad headers at [lo,hi]
  // and optionally on the final block.
  task automatic run_window(input int lo, input int hi, input logic last_bad);
    logic bad;
    for (int p = 0; p < WINDOW_SIZE; p++) begin
      bad = (p >= lo && p <= hi) || (last_bad && p == WINDOW_SIZE - 1);
      cycle(1'b1, 1'b1, bad ? bad_hdr() : good_hdr(), rnd64(), 1'b1);
    end
  endtask

  typedef struct {
    logic        present;
    logic        ready;
    logic        exp_valid;
    int          src;
    logic [15:0] exp_drop;
    logic [63:0] plain;
  } bp_vec_t;

  bp_vec_t tbl [10];

  initial begin
    logic [63:0] c;
    int rates [4];

    tbl[0] = '{1'b1, 1'b0, 1'b1, 0, 16'd0, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 0, 16'd1, 64'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 0, 16'd2, 64'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 0, 16'd3, 64'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 0, 16'd4, 64'h0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 0, 16'd4, 64'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 6, 16'd4, 64'h0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 7, 16'd4, 64'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 7, 16'd4, 64'h0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 0, 16'd4, 64'h0};
    for (int k = 0; k < 10; k++) tbl[k].plain = {32'hDA7A5EED, 28'h0123456, 4'(k)};

    // Lock acquisition from reset
    do_reset();
    for (int b = 1; b <= LOCK_COUNT; b++) begin
      cycle(1'b1, 1'b1, 2'b01, rnd64(), 1'b1);
      if (b == LOCK_COUNT - 1) check("lock_early", 64'(block_lock), 64'd0);
    end
    check("lock_at_65", 64'(block_lock), 64'd1);
    check("lock_slip_cnt", 64'(slip_cnt), 64'd0);
    check("lock_no_out_yet", 64'(out_valid), 64'd0);
    cycle(1'b1, 1'b1, 2'b01, rnd64(), 1'b1);
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_header", 64'(out_header), 64'h1);
    $display("phase lock: block_lock=%0b slip_cnt=%0d", block_lock, slip_cnt);

    // Bad header while hunting -> slip and wait
    do_reset();
    for (int b = 1; b <= 9; b++) cycle(1'b1, 1'b1, good_hdr(), rnd64(), 1'b1);
    cycle(1'b1, 1'b1, 2'b11, rnd64(), 1'b1);
    check("hunt_slip_pulse", 64'(gty_rx_gearboxslip), 64'd1);
    for (int n = 0; n < SLIP_WAIT + 1; n++) begin
      cycle(1'b1, 1'b1, 2'b00, rnd64(), 1'b1);
      if (n == 0) begin
        check("hunt_slip_single", 64'(gty_rx_gearboxslip), 64'd0);
        check("hunt_slip_cnt", 64'(slip_cnt), 64'd1);
      end
    end
    for (int b = 1; b <= LOCK_COUNT; b++) begin
      cycle(1'b1, 1'b1, good_hdr(), rnd64(), 1'b1);
      if (b == LOCK_COUNT - 1) check("relock_early", 64'(block_lock), 64'd0);
    end
    check("relock", 64'(block_lock), 64'd1);
    check("relock_slip_cnt", 64'(slip_cnt), 64'd1);
    $display("phase slip: block_lock=%0b slip_cnt=%0d", block_lock, slip_cnt);

    // Bad-header windows while locked
    run_window(WINDOW_SIZE - 15, WINDOW_SIZE - 1, 1'b0);
    check("win1_hold", 64'(block_lock), 64'd1);
    run_window(0, 14, 1'b0);
    check("win2_hold", 64'(block_lock), 64'd1);
    run_window(0, 14, 1'b1);
    check("win3_unlock", 64'(block_lock), 64'd0);
    check("win3_slip", 64'(gty_rx_gearboxslip), 64'd1);
    $display("phase window: block_lock=%0b slip=%0b", block_lock, gty_rx_gearboxslip);

    // Scrambled idle stream
    do_reset();
    sc = 58'h3FF_FFFF_FFFF_FFFF;
    for (int b = 1; b <= LOCK_COUNT + 12; b++) begin
      scramble(64'h0, c);
      cycle(1'b1, 1'b1, 2'b01, c, 1'b1);
      if (b > LOCK_COUNT) begin
        check("idle_valid", 64'(out_valid), 64'd1);
        check("idle_zero", out_data, 64'h0);
      end
    end
    $display("phase idle: out_data=%h", out_data);

    // Backpressure table
    cycle(1'b0, 1'b0, 2'b01, 64'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (tbl[k].present) scramble(tbl[k].plain, c);
      else c = rnd64();
      cycle(tbl[k].present, tbl[k].present, 2'b01, c, tbl[k].ready);
      check("bp_valid", 64'(out_valid), 64'(tbl[k].exp_valid));
      check("bp_drop", 64'(drop_cnt), 64'(tbl[k].exp_drop));
      if (tbl[k].exp_valid) check("bp_data", out_data, tbl[tbl[k].src].plain);
      $display("bp[%0d] present=%0b ready=%0b out_valid=%0b drop_cnt=%0d",
               k, tbl[k].present, tbl[k].ready, out_valid, drop_cnt);
    end

    // Reset while a block is buffered and locked
    cycle(1'b1, 1'b1, 2'b10, rnd64(), 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_lock", 64'(block_lock), 64'd1);
    do_reset();
    for (int b = 1; b <= LOCK_COUNT; b++) begin
      cycle(1'b1, 1'b1, good_hdr(), rnd64(), 1'b1);
      if (b == LOCK_COUNT - 1) check("post_rst_hunt", 64'(block_lock), 64'd0);
    end
    check("post_rst_lock", 64'(block_lock), 64'd1);
    $display("phase reset: drop_cnt=%0d block_lock=%0b", drop_cnt, block_lock);

    // Randomized traffic against the reference model
    do_reset();
    rates = '{0, 300, 40, 8};
    for (int seg = 0; seg < 4; seg++) begin
      for (int n = 0; n < 800; n++) begin
        logic dv, hv, bad, rdy;
        dv  = ($urandom_range(0, 9) != 0);
        hv  = ($urandom_range(0, 19) != 0);
        bad = (rates[seg] != 0) && ($urandom_range(0, rates[seg] - 1) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        cycle(dv, hv, bad ? bad_hdr() : good_hdr(), rnd64(), rdy);
      end
      $display("phase random seg %0d: block_lock=%0b slip_cnt=%0d drop_cnt=%0d",
               seg, block_lock, slip_cnt, drop_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
